seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_refresh_tick.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

   localparam int unsigned NUM_DIGITS      = 8;
   localparam int unsigned REFRESH_DIV_MIN = 2;
   localparam logic [7:0]  AN_ALL_OFF      = 8'hFF;

   typedef logic [2:0] digit_idx_t;

   // Bit i set when nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never flagged.
   function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] value);
      logic [NUM_DIGITS-1:0] mask;
      logic                  upper_zero;
      mask       = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero = upper_zero & (value[4*i +: 4] == 4'h0);
         mask[i]    = upper_zero;
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_refresh_tick.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and flags the last count of each slot.
module seg_refresh_tick
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   // Divisors below the legal minimum are clamped rather than producing a degenerate counter.
   localparam int unsigned      DIV_EFF  = (REFRESH_DIV < REFRESH_DIV_MIN) ? REFRESH_DIV_MIN : REFRESH_DIV;
   localparam int unsigned      CNT_W    = $clog2(DIV_EFF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tick = (count_q == CNT_LAST);

   // Next prescaler count, wrapping on the tick cycle.
   always_comb begin
      if (tick) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with double-buffered word (pending -> active at frame boundary).
// Optional feature: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_value,
   input  logic [7:0]  in_digit_en,
   output logic [3:0]  nibble,
   output logic        blank,
   output logic [7:0]  an,
   output logic [2:0]  digit_idx,
   output logic        frame_done
);

   localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

   logic        tick_s;
   logic        accept_s;
   logic        boundary_s;
   logic [7:0]  blank_mask_s;

   logic [31:0] pend_value_q, pend_value_d;
   logic [7:0]  pend_en_q,    pend_en_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] act_value_q,  act_value_d;
   logic [7:0]  act_en_q,     act_en_d;
   digit_idx_t  idx_q,        idx_d;
   logic [3:0]  nibble_q,     nibble_d;
   logic        blank_q,      blank_d;
   logic [7:0]  an_q,         an_d;
   logic        frame_done_q, frame_done_d;

   seg_refresh_tick #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_s)
   );

   assign in_ready   = ~pend_valid_q;
   assign accept_s   = in_valid & ~pend_valid_q;
   assign boundary_s = tick_s & (idx_q == LAST_DIGIT);

   // Word stores and scan index; active only changes at a frame boundary so a frame never mixes words.
   always_comb begin
      pend_value_d = pend_value_q;
      pend_en_d    = pend_en_q;
      pend_valid_d = pend_valid_q;
      act_value_d  = act_value_q;
      act_en_d     = act_en_q;
      idx_d        = idx_q;
      frame_done_d = boundary_s;

      if (boundary_s && pend_valid_q) begin
         act_value_d  = pend_value_q;
         act_en_d     = pend_en_q;
         pend_valid_d = 1'b0;
      end else begin
         act_value_d  = act_value_q;
      end

      // Accept only happens with pending empty, so it never collides with the transfer above.
      if (accept_s) begin
         pend_value_d = in_value;
         pend_en_d    = in_digit_en;
         pend_valid_d = 1'b1;
      end else begin
         pend_value_d = pend_value_q;
      end

      if (tick_s) begin
         idx_d = idx_q + digit_idx_t'(1);
      end else begin
         idx_d = idx_q;
      end
   end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   assign blank_mask_s = ~act_en_d | lead_zero_mask(act_value_d);
`else
   assign blank_mask_s = ~act_en_d;
`endif

   // Display outputs computed from next-state so they change on the same edge as the index.
   always_comb begin
      blank_d = blank_mask_s[idx_d];
      if (blank_d) begin
         an_d     = AN_ALL_OFF;
         nibble_d = 4'h0;
      end else begin
         an_d     = ~(8'h01 << idx_d);
         nibble_d = act_value_d[{idx_d, 2'b00} +: 4];
      end
   end

   // State and registered output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_value_q <= 32'h0000_0000;
         pend_en_q    <= 8'h00;
         pend_valid_q <= 1'b0;
         act_value_q  <= 32'h0000_0000;
         act_en_q     <= 8'h00;
         idx_q        <= '0;
         nibble_q     <= 4'h0;
         blank_q      <= 1'b1;
         an_q         <= AN_ALL_OFF;
         frame_done_q <= 1'b0;
      end else begin
         pend_value_q <= pend_value_d;
         pend_en_q    <= pend_en_d;
         pend_valid_q <= pend_valid_d;
         act_value_q  <= act_value_d;
         act_en_q     <= act_en_d;
         idx_q        <= idx_d;
         nibble_q     <= nibble_d;
         blank_q      <= blank_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign nibble     = nibble_q;
   assign blank      = blank_q;
   assign an         = an_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV = 4; expectations are queued per clock and checked on negedge.
module tb_seg_scan_ctrl;

   localparam int DIV = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [7:0]  in_digit_en;
   logic [3:0]  nibble;
   logic        blank;
   logic [7:0]  an;
   logic [2:0]  digit_idx;
   logic        frame_done;

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] nib;
      logic       blank;
      logic [7:0] an;
      logic       fd;
      logic       rdy;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp;
   int   n_bad;

   // expected-behaviour state
   int         m_cnt;
   logic [2:0] m_idx;
   logic [31:0] m_act_val, m_pend_val;
   logic [7:0]  m_act_en, m_pend_en;
   logic        m_pend_v;
   logic        m_fd;

   seg_scan_ctrl #(
      .REFRESH_DIV (DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_value    (in_value),
      .in_digit_en (in_digit_en),
      .nibble      (nibble),
      .blank       (blank),
      .an          (an),
      .digit_idx   (digit_idx),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic exp_t make_exp(input logic [2:0] idx, input logic [31:0] val,
                                     input logic [7:0] en, input logic fd, input logic rdy);
      exp_t r;
      logic [7:0] bm;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      logic z;
`endif
      bm = ~en;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      z = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         z     = z & (val[4*i +: 4] == 4'h0);
         bm[i] = bm[i] | z;
      end
`endif
      r.idx   = idx;
      r.blank = bm[idx];
      r.an    = r.blank ? 8'hFF : ~(8'h01 << idx);
      r.nib   = r.blank ? 4'h0 : val[4*int'(idx) +: 4];
      r.fd    = fd;
      r.rdy   = rdy;
      return r;
   endfunction

   task automatic model_reset();
      m_cnt      = 0;
      m_idx      = 3'd0;
      m_act_val  = 32'h0;
      m_act_en   = 8'h00;
      m_pend_val = 32'h0;
      m_pend_en  = 8'h00;
      m_pend_v   = 1'b0;
      m_fd       = 1'b0;
   endtask

   // Advance the expected state across one rising edge and queue what the DUT should then show.
   task automatic model_edge(input logic v, input logic [31:0] val, input logic [7:0] en);
      logic tk, bnd, acc;
      if (!rst_n) begin
         model_reset();
      end else begin
         tk   = (m_cnt == DIV - 1);
         bnd  = tk && (m_idx == 3'd7);
         acc  = v && !m_pend_v;
         m_fd = bnd;
         if (bnd && m_pend_v) begin
            m_act_val = m_pend_val;
            m_act_en  = m_pend_en;
            m_pend_v  = 1'b0;
         end
         if (acc) begin
            m_pend_val = val;
            m_pend_en  = en;
            m_pend_v   = 1'b1;
         end
         m_cnt = tk ? 0 : m_cnt + 1;
         if (tk) m_idx = m_idx + 3'd1;
      end
      exp_q.push_back(make_exp(m_idx, m_act_val, m_act_en, m_fd, !m_pend_v));
   endtask

   task automatic cycle_in(input logic v, input logic [31:0] val, input logic [7:0] en);
      in_valid    = v;
      in_value    = val;
      in_digit_en = en;
      @(posedge clk);
      model_edge(v, val, en);
      #1;
      in_valid    = 1'b0;
      in_value    = $urandom;
      in_digit_en = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle_in(1'b0, $urandom, 8'($urandom));
   endtask

   task automatic idle_until_slot(input logic [2:0] idx, input int cnt);
      for (int i = 0; i < 64; i++) begin
         if (m_idx == idx && m_cnt == cnt) break;
         idle(1);
      end
   endtask

   // Monitor: every negedge with an outstanding expectation is a presented DUT state to compare.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("digit_idx",  32'(digit_idx),  32'(mon_e.idx));
         chk("nibble",     32'(nibble),     32'(mon_e.nib));
         chk("blank",      32'(blank),      32'(mon_e.blank));
         chk("an",         32'(an),         32'(mon_e.an));
         chk("frame_done", 32'(frame_done), 32'(mon_e.fd));
         chk("in_ready",   32'(in_ready),   32'(mon_e.rdy));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc_b;
      int   n;
      n_cmp       = 0;
      n_bad       = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_value    = 32'h0;
      in_digit_en = 8'h00;
      model_reset();

      // Reset held, then released; first cycles must show the dark reset state.
      idle(3);
      rst_n = 1'b1;

      // Load before the first boundary, then watch two full frames.
      cycle_in(1'b1, 32'h1234_5678, 8'hFF);
      idle(70);

      // Back-pressure: two words offered back-to-back mid-frame.
      idle_until_slot(3'd2, 1);
      cycle_in(1'b1, 32'h9ABC_DEF0, 8'hFF);
      n = 0;
      do begin
         acc_b = !m_pend_v;
         cycle_in(1'b1, 32'h1357_9BDF, 8'hFF);
         n++;
      end while (!acc_b && n < 100);
      chk("second_word_accepted", 32'(acc_b), 32'(1'b1));
      idle(70);

      // Digit-enable mask.
      idle_until_slot(3'd4, 0);
      cycle_in(1'b1, 32'hFFFF_FFFF, 8'h0F);
      idle(70);

      // Leading-zero value.
      cycle_in(1'b1, 32'h0000_0A00, 8'hFF);
      idle(70);

      // Offer exactly on the boundary cycle with pending empty: must wait one more frame.
      idle_until_slot(3'd7, DIV - 1);
      cycle_in(1'b1, 32'h0F1E_2D3C, 8'hAA);
      idle(70);

      // Reset mid-frame at digit 5 with a word pending.
      idle_until_slot(3'd0, 0);
      cycle_in(1'b1, 32'h8765_4321, 8'hFF);
      idle_until_slot(3'd5, 1);
      rst_n = 1'b0;
      model_reset();
      void'(exp_q.pop_back());
      exp_q.push_back(make_exp(3'd0, 32'h0, 8'h00, 1'b0, 1'b1));
      idle(2);
      rst_n = 1'b1;
      idle(40);

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
